// File: rtl/pmem_burst_pkg.sv
// Shared constants, types and helpers for the L2 physical-memory burst responder.
// Converts line-wide requests into BEATS-beat bursts.
package pmem_burst_pkg;

    localparam int unsigned LINE_WIDTH  = 256;
    localparam int unsigned BURST_WIDTH = 64;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned CNT_WIDTH   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LINE_BYTES  = LINE_WIDTH / 8;
    localparam int unsigned OFFSET_BITS = $clog2(LINE_BYTES);

    typedef logic [LINE_WIDTH-1:0]  line_t;
    typedef logic [BURST_WIDTH-1:0] beat_t;
    typedef logic [ADDR_WIDTH-1:0]  addr_t;
    typedef logic [CNT_WIDTH-1:0]   cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_READ_BURST  = 2'd1,
        ST_WRITE_BURST = 2'd2,
        ST_DONE        = 2'd3
    } state_e;

    // Clear the byte-offset bits so the burst always starts on a line boundary.
    function automatic addr_t line_align(input addr_t addr);
        return addr & ~addr_t'(LINE_BYTES - 1);
    endfunction

    // Beat count must be a power of two so the counter wraps naturally.
    function automatic bit beats_is_pow2();
        return (BEATS != 0) && ((BEATS & (BEATS - 1)) == 0);
    endfunction

endpackage : pmem_burst_pkg

// File: rtl/pmem_line_buffer.sv
// One cacheline of storage: full-line parallel load, per-beat write at an
// index, and a combinational per-beat read mux.
module pmem_line_buffer
    import pmem_burst_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load_en,
    input  line_t load_line,
    input  logic  beat_we,
    input  cnt_t  wr_idx,
    input  beat_t wr_beat,
    input  cnt_t  rd_idx,
    output line_t line,
    output beat_t rd_beat_c
);

    // Full-line load takes priority over a beat write; the FSM never asks for both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line <= '0;
        end else if (load_en) begin
            line <= load_line;
        end else if (beat_we) begin
            for (int i = 0; i < int'(BEATS); i++) begin
                if (wr_idx == cnt_t'(i)) begin
                    line[i*BURST_WIDTH +: BURST_WIDTH] <= wr_beat;
                end
            end
        end
    end

    always_comb begin
        rd_beat_c = '0;
        for (int i = 0; i < int'(BEATS); i++) begin
            if (rd_idx == cnt_t'(i)) begin
                rd_beat_c = line[i*BURST_WIDTH +: BURST_WIDTH];
            end
        end
    end

endmodule : pmem_line_buffer

// File: rtl/pmem_burst_responder.sv
// Memory-side responder for the L2 line interface: turns each line read or
// write into a BEATS-beat burst and returns one pmem_resp pulse per line.
module pmem_burst_responder
    import pmem_burst_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  pmem_address,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [LINE_WIDTH-1:0]  pmem_wdata,
    output logic [LINE_WIDTH-1:0]  pmem_rdata,
    output logic                   pmem_resp,
    output logic [ADDR_WIDTH-1:0]  burst_address,
    output logic                   burst_read,
    output logic                   burst_write,
    output logic [BURST_WIDTH-1:0] burst_wdata,
    input  logic [BURST_WIDTH-1:0] burst_rdata,
    input  logic                   burst_resp
);

    localparam cnt_t LAST_BEAT = cnt_t'(BEATS - 1);
    localparam bit   BEATS_OK  = beats_is_pow2();

    state_e state_q;
    state_e state_d;
    cnt_t   cnt_q;
    cnt_t   cnt_d;
    addr_t  addr_d;
    beat_t  wdata_d;
    logic   load_en;
    logic   beat_we;
    logic   burst_read_d;
    logic   burst_write_d;
    logic   pmem_resp_d;
    line_t  buf_line;
    beat_t  buf_beat_c;

    pmem_line_buffer u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_line (pmem_wdata),
        .beat_we   (beat_we),
        .wr_idx    (cnt_q),
        .wr_beat   (burst_rdata),
        .rd_idx    (cnt_d),
        .line      (buf_line),
        .rd_beat_c (buf_beat_c)
    );

    assign pmem_rdata = buf_line;

    // Next-state, counter and next-output decode; registered outputs follow state_d.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = burst_address;
        load_en = 1'b0;
        beat_we = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pmem_write) begin
                    state_d = ST_WRITE_BURST;
                    cnt_d   = '0;
                    addr_d  = line_align(pmem_address);
                    load_en = 1'b1;
                end else if (pmem_read) begin
                    state_d = ST_READ_BURST;
                    cnt_d   = '0;
                    addr_d  = line_align(pmem_address);
                end
            end
            ST_READ_BURST: begin
                if (burst_resp) begin
                    beat_we = 1'b1;
                    cnt_d   = cnt_t'(cnt_q + cnt_t'(1));
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WRITE_BURST: begin
                if (burst_resp) begin
                    cnt_d = cnt_t'(cnt_q + cnt_t'(1));
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The buffer is not yet loaded on accept, so beat 0 comes straight from pmem_wdata.
        wdata_d       = load_en ? pmem_wdata[BURST_WIDTH-1:0] : buf_beat_c;
        burst_read_d  = (state_d == ST_READ_BURST);
        burst_write_d = (state_d == ST_WRITE_BURST);
        pmem_resp_d   = (state_d == ST_DONE) && BEATS_OK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            burst_address <= '0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
            burst_wdata   <= '0;
            pmem_resp     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            burst_address <= addr_d;
            burst_read    <= burst_read_d;
            burst_write   <= burst_write_d;
            burst_wdata   <= wdata_d;
            pmem_resp     <= pmem_resp_d;
        end
    end

endmodule : pmem_burst_responder

// File: tb/tb_pmem_burst_responder.sv
// Self-checking bench for pmem_burst_responder: directed cases plus randomized
// line transactions checked against a line-level memory/L2 model.
module tb_pmem_burst_responder;
    import pmem_burst_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    addr_t pmem_address;
    logic  pmem_read;
    logic  pmem_write;
    line_t pmem_wdata;
    line_t pmem_rdata;
    logic  pmem_resp;
    addr_t burst_address;
    logic  burst_read;
    logic  burst_write;
    beat_t burst_wdata;
    beat_t burst_rdata;
    logic  burst_resp;

    int    total = 0;
    int    bad   = 0;
    int    illegal_seen = 0;
    line_t exp_buf = '0;

    pmem_burst_responder dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_address  (pmem_address),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    always #5 clk = ~clk;

    // Flags the illegal read+write combination from the L2 side.
    always @(posedge clk) begin
        if (!rst && pmem_read && pmem_write) illegal_seen++;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < LINE_WIDTH / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic beat_t rand_beat();
        return {$urandom, $urandom};
    endfunction

    // One L2 line request served by a memory model; gap_mode 0=back-to-back, 1=alternate, 2=random.
    task automatic run_txn(input bit wr, input bit both, input addr_t addr, input line_t wline,
                           input line_t rline, input int gap_mode, input bit chk_lat);
        int    k;
        int    cyc;
        bit    done;
        bit    give;
        addr_t exp_addr;
        line_t exp_rd;
        exp_addr = {addr[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};
        exp_rd   = wr ? wline : rline;
        @(negedge clk);
        pmem_address = addr;
        pmem_read    = !wr || both;
        pmem_write   = wr;
        pmem_wdata   = wr ? wline : rand_line();
        k = 0; cyc = 0; done = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            burst_resp  = 1'b0;
            burst_rdata = rand_beat();
            if (pmem_resp) begin
                check("beats_at_resp", 256'(k), 256'(BEATS));
                check("rdata_at_resp", pmem_rdata, exp_rd);
                if (chk_lat) check("resp_latency", 256'(cyc), 256'(BEATS + 1));
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
                pmem_address = addr_t'($urandom);
                done = 1;
            end else begin
                check("burst_read",  256'(burst_read),  256'(!wr));
                check("burst_write", 256'(burst_write), 256'(wr));
                check("burst_addr",  256'(burst_address), 256'(exp_addr));
                if (wr && k < int'(BEATS))
                    check("burst_wdata", 256'(burst_wdata), 256'(wline[k*BURST_WIDTH +: BURST_WIDTH]));
                case (gap_mode)
                    0:       give = 1'b1;
                    1:       give = (cyc % 2) == 0;
                    default: give = ($urandom % 3) != 0;
                endcase
                if (k >= int'(BEATS)) give = 1'b0;
                if (give) begin
                    burst_resp  = 1'b1;
                    burst_rdata = rline[k*BURST_WIDTH +: BURST_WIDTH];
                    k++;
                end
            end
        end
        if (!done) check("resp_timeout", 256'(cyc), 256'(0));
        @(negedge clk);
        check("resp_once",  256'(pmem_resp), 256'(0));
        check("idle_read",  256'(burst_read), 256'(0));
        check("idle_write", 256'(burst_write), 256'(0));
        exp_buf = exp_rd;
    endtask

    // Beats offered while idle must leave the design untouched.
    task automatic spurious_beats(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            burst_resp  = 1'b1;
            burst_rdata = rand_beat();
        end
        @(negedge clk);
        burst_resp = 1'b0;
        @(negedge clk);
        check("spur_resp",  256'(pmem_resp), 256'(0));
        check("spur_read",  256'(burst_read), 256'(0));
        check("spur_rdata", pmem_rdata, exp_buf);
    endtask

    initial begin
        line_t l1, l2;
        rst = 1'b1;
        pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0; pmem_wdata = '0;
        burst_rdata = '0; burst_resp = 1'b0;
        #12;
        check("rst_resp",  256'(pmem_resp), 256'(0));
        check("rst_read",  256'(burst_read), 256'(0));
        check("rst_write", 256'(burst_write), 256'(0));
        check("rst_rdata", pmem_rdata, 256'(0));
        check("rst_addr",  256'(burst_address), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // Directed read, back-to-back beats
        l1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        run_txn(1'b0, 1'b0, 32'h0000_1234, '0, l1, 0, 1'b1);

        // Directed write, beats on alternate cycles
        l2 = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        run_txn(1'b1, 1'b0, 32'h0000_0040, l2, rand_line(), 1, 1'b0);

        // Reset in the middle of a read burst
        @(negedge clk);
        pmem_address = 32'h0000_0080; pmem_read = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            burst_resp = 1'b1; burst_rdata = rand_beat();
        end
        @(negedge clk);
        burst_resp = 1'b0;
        check("mid_read_pre", 256'(burst_read), 256'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_read",  256'(burst_read), 256'(0));
        check("mid_rst_resp",  256'(pmem_resp), 256'(0));
        check("mid_rst_rdata", pmem_rdata, 256'(0));
        pmem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_buf = '0;
        run_txn(1'b0, 1'b0, 32'h0000_0080, '0, rand_line(), 0, 1'b1);

        // Spurious idle beats, then read followed directly by write
        spurious_beats(3);
        run_txn(1'b0, 1'b0, $urandom, '0, rand_line(), 2, 1'b0);
        run_txn(1'b1, 1'b0, $urandom, rand_line(), rand_line(), 0, 1'b1);

        // Simultaneous read and write: write wins
        check("illegal_before", 256'(illegal_seen), 256'(0));
        run_txn(1'b1, 1'b1, 32'h0000_0100, rand_line(), rand_line(), 0, 1'b1);
        check("illegal_flagged", 256'(illegal_seen > 0), 256'(1));

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) spurious_beats($urandom_range(1, 3));
            run_txn(1'($urandom_range(0, 1)), 1'b0, $urandom, rand_line(), rand_line(),
                    $urandom_range(0, 2), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_pmem_burst_responder
